// File: rtl/pdp10_membus_pkg.sv
// rtl/pdp10_membus_pkg.sv - shared widths, state encoding and round-robin helper for the memory-bus arbiter
package pdp10_membus_pkg;
  localparam int MA_W   = 15;
  localparam int WORD_W = 36;
  localparam int SEL_W  = 4;
  localparam int TMO_W  = 10;
  localparam int IDX_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_RDATA = 3'd2,
    ST_WDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Index of the master 'off' places after 'base' in round-robin order.
  function automatic logic [IDX_W-1:0] rr_wrap(input int base, input int off, input int n);
    return IDX_W'((base + off) % n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester after the pointer wins
module rr_pick
  import pdp10_membus_pkg::*;
#(
  parameter int NM = 4
) (
  input  logic [NM-1:0]    req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NM-1:0]    onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from farthest to nearest so the requester closest after ptr is left in idx.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int off = NM; off >= 1; off--) begin
      if (req[rr_wrap(int'(ptr), off, NM)]) begin
        idx = rr_wrap(int'(ptr), off, NM);
      end
    end
    onehot[idx] = any;
  end

endmodule

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - round-robin arbiter sharing one core-memory slave port among NM masters
module membus_arbiter
  import pdp10_membus_pkg::*;
#(
  parameter int NM      = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NM-1:0]       m_rq_cyc,
  input  logic [NM-1:0]       m_rd_rq,
  input  logic [NM-1:0]       m_wr_rq,
  input  logic [NM*15-1:0]    m_ma,
  input  logic [NM*4-1:0]     m_sel,
  input  logic [NM-1:0]       m_fmc_select,
  input  logic [NM*36-1:0]    m_mb_write,
  input  logic [NM-1:0]       m_wr_rs,
  output logic [NM-1:0]       m_addr_ack,
  output logic [NM-1:0]       m_rd_rs,
  output logic [NM-1:0]       m_nxm,
  output logic [35:0]         m_mb_read,
  output logic                s_rq_cyc,
  output logic                s_rd_rq,
  output logic                s_wr_rq,
  output logic                s_fmc_select,
  output logic                s_wr_rs,
  output logic [14:0]         s_ma,
  output logic [3:0]          s_sel,
  output logic [35:0]         s_mb_write,
  input  logic                s_addr_ack,
  input  logic                s_rd_rs,
  input  logic [35:0]         s_mb_read,
  output logic [2:0]          grant,
  output logic                busy
);

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [NM-1:0]      grant_oh;
  logic [TMO_W-1:0]   tcnt;

  logic [NM-1:0]      pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               g_rq, g_rd, g_wr, g_fmc, g_wrs;
  logic [MA_W-1:0]    g_ma;
  logic [SEL_W-1:0]   g_sel;
  logic [WORD_W-1:0]  g_mbw;
  logic               tmo_hit, ack_ok, fwd;

  rr_pick #(.NM(NM)) u_pick (
    .req    (m_rq_cyc),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    g_rq  = m_rq_cyc[grant];
    g_rd  = m_rd_rq[grant];
    g_wr  = m_wr_rq[grant];
    g_fmc = m_fmc_select[grant];
    g_wrs = m_wr_rs[grant];
    g_ma  = m_ma[int'(grant)*MA_W +: MA_W];
    g_sel = m_sel[int'(grant)*SEL_W +: SEL_W];
    g_mbw = m_mb_write[int'(grant)*WORD_W +: WORD_W];
  end

  assign tmo_hit = (tcnt == TMO_W'(TIMEOUT - 1));
  // An ack only counts once the slave has actually seen our request.
  assign ack_ok  = s_addr_ack && s_rq_cyc;
  assign busy    = (state != ST_IDLE);

  // fwd: the slave copies stay live this edge; otherwise every s_* output is dropped.
  always_comb begin
    fwd = 1'b0;
    case (state)
      ST_ADDR:  fwd = g_rq && (ack_ok || !tmo_hit);
      ST_RDATA: fwd = g_rq && !(s_rd_rs && !g_wr);
      ST_WDATA: fwd = g_rq;
      default:  fwd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      ptr          <= IDX_W'(NM - 1);
      grant        <= '0;
      grant_oh     <= '0;
      tcnt         <= '0;
      m_addr_ack   <= '0;
      m_rd_rs      <= '0;
      m_nxm        <= '0;
      m_mb_read    <= '0;
      s_rq_cyc     <= 1'b0;
      s_rd_rq      <= 1'b0;
      s_wr_rq      <= 1'b0;
      s_fmc_select <= 1'b0;
      s_wr_rs      <= 1'b0;
      s_ma         <= '0;
      s_sel        <= '0;
      s_mb_write   <= '0;
    end else begin
      m_addr_ack   <= '0;
      m_rd_rs      <= '0;
      m_nxm        <= '0;
      s_rq_cyc     <= fwd & g_rq;
      s_rd_rq      <= fwd & g_rd;
      s_wr_rq      <= fwd & g_wr;
      s_fmc_select <= fwd & g_fmc;
      s_wr_rs      <= fwd & g_wrs;
      s_ma         <= fwd ? g_ma  : '0;
      s_sel        <= fwd ? g_sel : '0;
      s_mb_write   <= fwd ? g_mbw : '0;

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= pick_idx;
            grant_oh <= pick_oh;
            ptr      <= pick_idx;
            tcnt     <= '0;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!g_rq) begin
            state <= ST_IDLE;
          end else if (ack_ok) begin
            m_addr_ack <= grant_oh;
            state      <= g_rd ? ST_RDATA : ST_WDATA;
          end else if (tmo_hit) begin
            m_nxm <= grant_oh;
            state <= ST_DONE;
          end else begin
            tcnt <= tcnt + TMO_W'(1);
          end
        end
        ST_RDATA: begin
          if (!g_rq) begin
            state <= ST_DONE;
          end else if (s_rd_rs) begin
            m_mb_read <= s_mb_read;
            m_rd_rs   <= grant_oh;
            state     <= g_wr ? ST_WDATA : ST_DONE;
          end
        end
        ST_WDATA: begin
          if (!g_rq) state <= ST_DONE;
        end
        ST_DONE: begin
          if (!g_rq) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
